// File: rtl/coeff_zigzag_quantizer_pkg.sv
// Shared definitions for the zig-zag coefficient quantizer: default widths,
// FSM state encoding and the zig-zag scan table.
package coeff_zigzag_quantizer_pkg;

    localparam int IN_W_DEF  = 15;
    localparam int OUT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Scan position -> bank position (row*4+col) for a 4x4 zig-zag.
    localparam logic [3:0] ZZ_POS [16] = '{
        4'd0,  4'd1,  4'd4,  4'd8,
        4'd5,  4'd2,  4'd3,  4'd6,
        4'd9,  4'd12, 4'd13, 4'd10,
        4'd7,  4'd11, 4'd14, 4'd15
    };

endpackage

// File: rtl/coeff_zigzag_quantizer_quantizer.sv
// Combinational power-of-two quantizer: round half away from zero, then
// saturate symmetrically to +/-(2^(OUT_W-1)-1).
module coeff_quantizer #(
    parameter int IN_W    = 15,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 4
) (
    input  logic signed [IN_W-1:0]  x,
    input  logic [SHIFT_W-1:0]      s,
    output logic signed [OUT_W-1:0] q
);

    // Two spare bits: one for |min|, one for the rounding add.
    localparam int MAG_W = IN_W + 2;
    localparam logic [MAG_W-1:0] SAT_MAX = MAG_W'((1 << (OUT_W - 1)) - 1);

    logic signed [IN_W:0] x_ext;
    logic [IN_W:0]        mag;
    logic                 neg;
    logic [MAG_W-1:0]     rounded;
    logic [OUT_W-1:0]     qm;

    function automatic logic [MAG_W-1:0] round_mag(input logic [MAG_W-1:0] m,
                                                   input logic [SHIFT_W-1:0] sh);
        logic [MAG_W-1:0] half;
        half = (sh == '0) ? '0 : (MAG_W'(1) << (sh - 1'b1));
        return (m + half) >> sh;
    endfunction

    function automatic logic [OUT_W-1:0] sat_mag(input logic [MAG_W-1:0] m);
        return (m > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : m[OUT_W-1:0];
    endfunction

    // Sign/magnitude split, round the magnitude, saturate, reapply the sign.
    always_comb begin
        neg     = x[IN_W-1];
        x_ext   = {x[IN_W-1], x};
        mag     = neg ? -x_ext : x_ext;
        rounded = round_mag({1'b0, mag}, s);
        qm      = sat_mag(rounded);
        q       = neg ? -$signed(qm) : $signed(qm);
    end

endmodule

// File: rtl/coeff_zigzag_quantizer.sv
// Captures a 4x4 coefficient block on the rising edge of data-available and
// streams quantized coefficients in zig-zag order over valid/ready.
module coeff_zigzag_quantizer
    import coeff_zigzag_quantizer_pkg::*;
#(
    parameter int IN_W      = IN_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int QSHIFT_DC = 3,
    parameter int QSHIFT_AC = 2
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_data_available,
    input  logic signed [IN_W-1:0]  in_T00,
    input  logic signed [IN_W-1:0]  in_T01,
    input  logic signed [IN_W-1:0]  in_T02,
    input  logic signed [IN_W-1:0]  in_T03,
    input  logic signed [IN_W-1:0]  in_T10,
    input  logic signed [IN_W-1:0]  in_T11,
    input  logic signed [IN_W-1:0]  in_T12,
    input  logic signed [IN_W-1:0]  in_T13,
    input  logic signed [IN_W-1:0]  in_T20,
    input  logic signed [IN_W-1:0]  in_T21,
    input  logic signed [IN_W-1:0]  in_T22,
    input  logic signed [IN_W-1:0]  in_T23,
    input  logic signed [IN_W-1:0]  in_T30,
    input  logic signed [IN_W-1:0]  in_T31,
    input  logic signed [IN_W-1:0]  in_T32,
    input  logic signed [IN_W-1:0]  in_T33,
    input  logic                    in_out_ready,
    input  logic                    in_clear_overrun,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_coeff,
    output logic [3:0]              out_index,
    output logic                    out_last,
    output logic                    out_busy,
    output logic                    out_block_done,
    output logic                    out_overrun
);

    localparam int SHIFT_W = $clog2(IN_W);

    state_t                 state;
    logic                   avail_q;
    logic signed [IN_W-1:0] bank     [16];
    logic signed [IN_W-1:0] coeff_in [16];
    logic [3:0]             idx;
    logic [3:0]             pos;
    logic [SHIFT_W-1:0]     shift;
    logic signed [OUT_W-1:0] q;
    logic                   capture;
    logic                   transfer;

    assign coeff_in = '{in_T00, in_T01, in_T02, in_T03,
                        in_T10, in_T11, in_T12, in_T13,
                        in_T20, in_T21, in_T22, in_T23,
                        in_T30, in_T31, in_T32, in_T33};

    assign capture  = in_data_available & ~avail_q;
    assign transfer = out_valid & in_out_ready;

    // Only the DC term (bank position 0) uses the coarser step.
    assign pos   = ZZ_POS[idx];
    assign shift = (pos == 4'd0) ? SHIFT_W'(QSHIFT_DC) : SHIFT_W'(QSHIFT_AC);

    coeff_quantizer #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W)
    ) u_quant (
        .x (bank[pos]),
        .s (shift),
        .q (q)
    );

    assign out_coeff = out_valid ? q : '0;
    assign out_index = idx;

    // Delay data-available by one cycle for rising-edge detection.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) avail_q <= 1'b0;
        else         avail_q <= in_data_available;
    end

    // Coefficient bank: loaded only from IDLE so a late block cannot corrupt a stream.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            for (int i = 0; i < 16; i++) bank[i] <= '0;
        end else if (state == IDLE && capture) begin
            bank <= coeff_in;
        end
    end

    // Control FSM: capture, stream 16 transfers, one DONE cycle.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state          <= IDLE;
            idx            <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            out_busy       <= 1'b0;
            out_block_done <= 1'b0;
        end else begin
            out_block_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        state     <= STREAM;
                        idx       <= '0;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        out_busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (transfer) begin
                        if (idx == 4'd15) begin
                            state          <= DONE;
                            out_valid      <= 1'b0;
                            out_last       <= 1'b0;
                            out_block_done <= 1'b1;
                        end else begin
                            idx      <= idx + 4'd1;
                            out_last <= (idx == 4'd14);
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    out_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky overrun: a capture while busy sets it, and set beats clear.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst)                        out_overrun <= 1'b0;
        else if (capture && state != IDLE)  out_overrun <= 1'b1;
        else if (in_clear_overrun)          out_overrun <= 1'b0;
    end

endmodule

// File: tb/tb_coeff_zigzag_quantizer.sv
// Scoreboard bench for coeff_zigzag_quantizer.
module tb_coeff_zigzag_quantizer;

    typedef struct { int coeff; int index; } exp_t;
    typedef struct { int coeff; int index; logic last; } obs_t;

    localparam int ZZ [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

    logic              clk;
    logic              in_rst;
    logic              in_data_available;
    logic signed [14:0] t   [16];
    logic signed [14:0] alt [16];
    logic              in_out_ready;
    logic              in_clear_overrun;
    logic              out_valid;
    logic signed [7:0] out_coeff;
    logic [3:0]        out_index;
    logic              out_last;
    logic              out_busy;
    logic              out_block_done;
    logic              out_overrun;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   done_pulses;
    int   stall_err;
    bit   timeout;
    bit   hold_avail = 0;

    coeff_zigzag_quantizer dut (
        .in_clk            (clk),
        .in_rst            (in_rst),
        .in_data_available (in_data_available),
        .in_T00 (t[0]),  .in_T01 (t[1]),  .in_T02 (t[2]),  .in_T03 (t[3]),
        .in_T10 (t[4]),  .in_T11 (t[5]),  .in_T12 (t[6]),  .in_T13 (t[7]),
        .in_T20 (t[8]),  .in_T21 (t[9]),  .in_T22 (t[10]), .in_T23 (t[11]),
        .in_T30 (t[12]), .in_T31 (t[13]), .in_T32 (t[14]), .in_T33 (t[15]),
        .in_out_ready      (in_out_ready),
        .in_clear_overrun  (in_clear_overrun),
        .out_valid         (out_valid),
        .out_coeff         (out_coeff),
        .out_index         (out_index),
        .out_last          (out_last),
        .out_busy          (out_busy),
        .out_block_done    (out_block_done),
        .out_overrun       (out_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference quantizer: integer division form of round-half-away-from-zero.
    function automatic int q_model(input int x, input int s);
        int a, m;
        a = (x < 0) ? -x : x;
        if (s == 0) m = a;
        else        m = (a + (1 << (s - 1))) / (1 << s);
        if (m > 127) m = 127;
        return (x < 0) ? -m : m;
    endfunction

    task automatic push_model();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.coeff = q_model(int'(t[ZZ[i]]), (ZZ[i] == 0) ? 3 : 2);
            e.index = i;
            exp_q.push_back(e);
        end
    endtask

    task automatic randomize_t();
        for (int k = 0; k < 16; k++) t[k] = 15'($urandom_range(0, 32767));
    endtask

    // Raise data-available for one rising edge (held if hold_avail).
    task automatic capture(input bit use_model);
        if (use_model) push_model();
        in_data_available = 1'b1;
        @(negedge clk);
        in_data_available = hold_avail;
    endtask

    // Collect transfers; optionally inject a second block at transfer inject_at.
    task automatic drain(input bit rnd, input int want, input int inject_at, input bit inject_clear);
        int   n = 0;
        int   cyc = 0;
        bit   prev_stall = 0;
        bit   injected = 0;
        obs_t o;
        obs_t prev;
        done_pulses = 0;
        stall_err   = 0;
        timeout     = 0;
        obs_q.delete();
        prev = '{0, 0, 1'b0};
        while (n < want) begin
            in_data_available = hold_avail;
            in_clear_overrun  = 1'b0;
            if (out_block_done) done_pulses++;
            if (prev_stall && (out_valid !== 1'b1 || int'(out_coeff) != prev.coeff ||
                               int'(out_index) != prev.index || out_last !== prev.last))
                stall_err++;
            if (inject_at == n && !injected) begin
                injected = 1;
                for (int k = 0; k < 16; k++) t[k] = alt[k];
                in_data_available = 1'b1;
                in_clear_overrun  = inject_clear;
            end
            in_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            o.coeff = int'(out_coeff);
            o.index = int'(out_index);
            o.last  = out_last;
            if (out_valid && in_out_ready) begin
                obs_q.push_back(o);
                n++;
            end
            prev_stall = out_valid && !in_out_ready;
            prev = o;
            @(negedge clk);
            cyc++;
            if (cyc > 400) begin
                timeout = 1;
                break;
            end
        end
        in_data_available = hold_avail;
        in_clear_overrun  = 1'b0;
        in_out_ready      = 1'b1;
    endtask

    task automatic test_reset();
        in_rst = 1'b0;
        #1;
        n_assert++;
        if ({out_valid, out_last, out_busy, out_block_done, out_overrun} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {out_valid, out_last, out_busy, out_block_done, out_overrun});
        end
        n_assert++;
        if (out_coeff !== 8'sd0 || out_index !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_data: got coeff=%0d idx=%0d want 0/0", out_coeff, out_index);
        end
        @(negedge clk);
        in_rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int   vals [16] = '{13, -2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_t e;
        for (int k = 0; k < 16; k++) t[k] = '0;
        t[0] = 15'sd100; t[1] = -15'sd6; t[4] = 15'sd7;
        for (int i = 0; i < 16; i++) begin e.coeff = vals[i]; e.index = i; exp_q.push_back(e); end
        capture(0);
        n_assert++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: valid=%b want 1", out_valid); end
        drain(0, 16, -1, 0);
        n_assert++;
        if (timeout || obs_q.size() != 16) begin
            n_fail++; $display("FAIL basic_count: got %0d transfers want 16", obs_q.size());
        end
        foreach (obs_q[i]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '{999, 99};
            n_assert++;
            if (obs_q[i].coeff != e.coeff || obs_q[i].index != e.index || obs_q[i].last !== (e.index == 15)) begin
                n_fail++;
                $display("FAIL basic[%0d]: got coeff=%0d idx=%0d last=%b want coeff=%0d idx=%0d",
                         i, obs_q[i].coeff, obs_q[i].index, obs_q[i].last, e.coeff, e.index);
            end
        end
        exp_q.delete();
        n_assert++;
        if (done_pulses != 0 || out_block_done !== 1'b1 || out_valid !== 1'b0 || out_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done: early=%0d done=%b valid=%b busy=%b want 0/1/0/1",
                     done_pulses, out_block_done, out_valid, out_busy);
        end
        @(negedge clk);
        n_assert++;
        if (out_block_done !== 1'b0 || out_busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_idle: done=%b busy=%b want 0/0", out_block_done, out_busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_order();
        int   vals [16] = '{1, 2, 5, 9, 6, 3, 4, 7, 10, 13, 14, 11, 8, 12, 15, 16};
        exp_t e;
        for (int k = 0; k < 16; k++) t[k] = 15'(4 * (k + 1));
        for (int i = 0; i < 16; i++) begin e.coeff = vals[i]; e.index = i; exp_q.push_back(e); end
        capture(0);
        drain(0, 16, -1, 0);
        n_assert++;
        if (timeout || obs_q.size() != 16) begin
            n_fail++; $display("FAIL order_count: got %0d transfers want 16", obs_q.size());
        end
        foreach (obs_q[i]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '{999, 99};
            n_assert++;
            if (obs_q[i].coeff != e.coeff || obs_q[i].index != e.index || obs_q[i].last !== (e.index == 15)) begin
                n_fail++;
                $display("FAIL order[%0d]: got coeff=%0d idx=%0d last=%b want coeff=%0d idx=%0d",
                         i, obs_q[i].coeff, obs_q[i].index, obs_q[i].last, e.coeff, e.index);
            end
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_saturation_held();
        exp_t e;
        for (int k = 0; k < 16; k++) t[k] = '0;
        t[0] = -15'sd4; t[1] = 15'sd16383; t[4] = -15'sd16384; t[5] = -15'sd2; t[6] = 15'sd1;
        hold_avail = 1'b1;
        capture(1);
        drain(0, 16, -1, 0);
        n_assert++;
        if (timeout || obs_q.size() != 16) begin
            n_fail++; $display("FAIL sat_count: got %0d transfers want 16", obs_q.size());
        end else begin
            n_assert++;
            if (obs_q[0].coeff != -1 || obs_q[1].coeff != 127 || obs_q[2].coeff != -127 ||
                obs_q[4].coeff != -1 || obs_q[7].coeff != 0) begin
                n_fail++;
                $display("FAIL sat_extremes: got %0d %0d %0d %0d %0d want -1 127 -127 -1 0",
                         obs_q[0].coeff, obs_q[1].coeff, obs_q[2].coeff, obs_q[4].coeff, obs_q[7].coeff);
            end
        end
        foreach (obs_q[i]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '{999, 99};
            n_assert++;
            if (obs_q[i].coeff != e.coeff || obs_q[i].index != e.index || obs_q[i].last !== (e.index == 15)) begin
                n_fail++;
                $display("FAIL sat[%0d]: got coeff=%0d idx=%0d want coeff=%0d idx=%0d",
                         i, obs_q[i].coeff, obs_q[i].index, e.coeff, e.index);
            end
        end
        exp_q.delete();
        repeat (6) @(negedge clk);
        n_assert++;
        if (out_valid !== 1'b0 || out_busy !== 1'b0 || out_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL held_level: valid=%b busy=%b overrun=%b want 0/0/0", out_valid, out_busy, out_overrun);
        end
        hold_avail = 1'b0;
        in_data_available = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure();
        exp_t e;
        randomize_t();
        capture(1);
        drain(1, 16, -1, 0);
        n_assert++;
        if (timeout || obs_q.size() != 16) begin
            n_fail++; $display("FAIL bp_count: got %0d transfers want 16", obs_q.size());
        end
        n_assert++;
        if (stall_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err); end
        foreach (obs_q[i]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '{999, 99};
            n_assert++;
            if (obs_q[i].coeff != e.coeff || obs_q[i].index != e.index || obs_q[i].last !== (e.index == 15)) begin
                n_fail++;
                $display("FAIL bp[%0d]: got coeff=%0d idx=%0d want coeff=%0d idx=%0d",
                         i, obs_q[i].coeff, obs_q[i].index, e.coeff, e.index);
            end
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_overrun();
        exp_t e;
        n_assert++;
        if (out_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_initial: got %b want 0", out_overrun); end
        randomize_t();
        for (int k = 0; k < 16; k++) alt[k] = 15'($urandom_range(0, 32767));
        capture(1);
        drain(0, 16, 5, 0);
        n_assert++;
        if (timeout || obs_q.size() != 16) begin
            n_fail++; $display("FAIL ovr_count: got %0d transfers want 16", obs_q.size());
        end
        foreach (obs_q[i]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '{999, 99};
            n_assert++;
            if (obs_q[i].coeff != e.coeff || obs_q[i].index != e.index) begin
                n_fail++;
                $display("FAIL ovr_block[%0d]: got coeff=%0d idx=%0d want coeff=%0d idx=%0d",
                         i, obs_q[i].coeff, obs_q[i].index, e.coeff, e.index);
            end
        end
        exp_q.delete();
        n_assert++;
        if (out_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", out_overrun); end
        repeat (2) @(negedge clk);
        in_clear_overrun = 1'b1;
        @(negedge clk);
        in_clear_overrun = 1'b0;
        n_assert++;
        if (out_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear1: got %b want 0", out_overrun); end
        randomize_t();
        for (int k = 0; k < 16; k++) alt[k] = 15'($urandom_range(0, 32767));
        capture(1);
        drain(0, 16, 3, 1);
        exp_q.delete();
        n_assert++;
        if (out_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b want 1", out_overrun); end
        repeat (2) @(negedge clk);
        in_clear_overrun = 1'b1;
        @(negedge clk);
        in_clear_overrun = 1'b0;
        n_assert++;
        if (out_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear2: got %b want 0", out_overrun); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        randomize_t();
        capture(1);
        drain(0, 8, -1, 0);
        n_assert++;
        if (out_valid !== 1'b1 || out_index !== 4'd8) begin
            n_fail++; $display("FAIL mid_pre: valid=%b idx=%0d want 1/8", out_valid, out_index);
        end
        in_rst = 1'b0;
        #1;
        n_assert++;
        if ({out_valid, out_last, out_busy, out_block_done, out_overrun} !== 5'b0 ||
            out_coeff !== 8'sd0 || out_index !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset: ctrl=%b coeff=%0d idx=%0d want 0",
                     {out_valid, out_last, out_busy, out_block_done, out_overrun}, out_coeff, out_index);
        end
        exp_q.delete();
        @(negedge clk);
        in_rst = 1'b1;
        repeat (2) @(negedge clk);
        randomize_t();
        capture(1);
        drain(0, 16, -1, 0);
        n_assert++;
        if (timeout || obs_q.size() != 16) begin
            n_fail++; $display("FAIL mid_count: got %0d transfers want 16", obs_q.size());
        end
        foreach (obs_q[i]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '{999, 99};
            n_assert++;
            if (obs_q[i].coeff != e.coeff || obs_q[i].index != e.index || obs_q[i].last !== (e.index == 15)) begin
                n_fail++;
                $display("FAIL mid_restart[%0d]: got coeff=%0d idx=%0d want coeff=%0d idx=%0d",
                         i, obs_q[i].coeff, obs_q[i].index, e.coeff, e.index);
            end
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        in_rst            = 1'b0;
        in_data_available = 1'b0;
        in_out_ready      = 1'b1;
        in_clear_overrun  = 1'b0;
        for (int k = 0; k < 16; k++) begin t[k] = '0; alt[k] = '0; end
        @(negedge clk);
        test_reset();
        test_basic();
        test_order();
        test_saturation_held();
        test_backpressure();
        test_overrun();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
